vu_commit_table: RTL and testbench
==================================

// Module: vu_commit_table
// PURPOSE
//  In-order commit table for vector-unit commands, placed in the scalar unit beside the hazard check table.
//  Each command issued to the vector unit allocates an entry: issue_no plus the enabled-lane mask.
//  Per-lane commit reports set bits in that entry. When every enabled lane has committed, entries retire
//  strictly in issue order and return issue_no to the hazard check table, which clears that entry.
// PARAMETERS
//  NUM_LANE        16   number of vector lanes
//  NUM_ENTRY       8    table depth; equals NUM_ENTRY_HAZARD
//  WIDTH_ENTRY     $clog2(NUM_ENTRY)   issue_no / pointer width
// PORTS
//  clock            in   1                      single clock, rising edge
//  reset            in   1                      synchronous, active-high
//  I_Issue          in   1                      allocate request from command dispatch
//  I_Issue_No       in   WIDTH_ENTRY            issue_no of dispatched command
//  I_En_Lane        in   NUM_LANE               lanes that will execute the command
//  O_Full           out  1                      no free entry
//  O_Empty          out  1                      no valid entry
//  I_Lane_Commit    in   NUM_LANE               per-lane commit strobe
//  I_Lane_Issue_No  in   NUM_LANE*WIDTH_ENTRY   per-lane committed issue_no; lane l uses slice [l*W +: W]
//  O_Commit         out  1                      retire pulse to hazard table
//  O_Commit_No      out  WIDTH_ENTRY            issue_no being retired
//  O_Pending        out  WIDTH_ENTRY+1          count of valid entries
//  O_Overflow       out  1                      sticky: issue while full
//  O_Stray          out  1                      1-cycle pulse: lane commit matched no entry
// BEHAVIOUR
//  Reset: all entries v=0, en_lane=0, en_commit=0, head=tail=0, count=0. Outputs O_Commit=0, O_Commit_No=0,
//   O_Overflow=0, O_Stray=0, O_Full=0, O_Empty=1, O_Pending=0. Reset mid-operation drops all entries; no retire pulses.
//  Storage: circular buffer with head/tail pointers, each modulo NUM_ENTRY. O_Full/O_Empty/O_Pending come
//   combinationally from the registered count.
//  Issue: when I_Issue=1 and O_Full=0, the next edge writes entry[tail] as {v=1, issue_no, en_lane=I_En_Lane,
//   en_commit=0}; tail increments. I_Issue=1 with O_Full=1 drops the request, sets O_Overflow, and leaves state unchanged.
//  Lane commit: for each lane l with I_Lane_Commit[l]=1, find the valid entry with issue_no equal to lane l's slice
//   and en_lane[l]=1; set its en_commit[l] at the next edge. All lanes update in parallel, and several may target
//   one entry. No match registers O_Stray=1 for one cycle. Dispatch guarantees valid issue_no values are unique.
//  Completion: entry complete when v && (en_commit == en_lane). en_lane=0 is complete immediately.
//  Retire (registered): if entry[head] is complete at cycle N, then at edge N+1: O_Commit=1, O_Commit_No=issue_no,
//   entry[head].v=0, head++. At most one retire per cycle, in order only. A complete non-head entry waits.
//  Latency: last lane commit sampled at cycle N -> en_commit full after edge N+1 -> O_Commit high in cycle N+2.
//   Back-to-back complete entries retire on consecutive cycles.
//  Simultaneous issue + retire: count unchanged; O_Full is from pre-edge count, so issue is rejected when full even
//   if a retire happens in the same cycle.
//  Issue into a slot freed this same edge is impossible, because full blocks it. tail==head with count=NUM_ENTRY is full.
//  Lane commit in the same cycle as that entry's issue: entry not yet valid -> stray.
//  Pointer wrap: after index NUM_ENTRY-1 the next index is 0; order is preserved across the wrap.
// TESTING
//  1 Reset: after reset, O_Empty=1, O_Pending=0, O_Commit=0. Issue no=3, lanes=16'h000F; commit lanes 0-3 at cycle 5
//    -> O_Commit=1, O_Commit_No=3 in cycle 7 only.
//  2 Out-of-order lanes: issue no=1 then no=2, each with lanes=16'h0003. Commit no=2 fully, then no=1 at a later cycle N
//    -> retire no=1 at N+2, no=2 at N+3.
//  3 Full/overflow: issue 8 entries -> O_Full=1, O_Pending=8. A 9th issue is dropped with O_Overflow=1 (sticky).
//    Retire one, then issue again -> accepted; the pointer wraps to 0.
//  4 Zero-lane command: issue no=5, lanes=0 into an empty table at cycle N -> O_Commit_No=5 in cycle N+2.
//  5 Stray: lane 4 commits no=6 with no entry holding it -> O_Stray pulses one cycle; table state unchanged.
//  6 Partial lanes plus reset: issue lanes=16'hFFFF, commit 15 lanes, assert reset -> no O_Commit ever;
//    all outputs return to reset values.

Source files
------------

// File: rtl/vu_commit_table.sv
// In-order commit table for vector-unit commands: tracks per-lane commit progress of each
// issued command and retires entries strictly in issue order back to the hazard table.
module vu_commit_table #(
  parameter int NUM_LANE    = 16,
  parameter int NUM_ENTRY   = 8,
  parameter int WIDTH_ENTRY = $clog2(NUM_ENTRY)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            I_Issue,
  input  logic [WIDTH_ENTRY-1:0]          I_Issue_No,
  input  logic [NUM_LANE-1:0]             I_En_Lane,
  output logic                            O_Full,
  output logic                            O_Empty,
  input  logic [NUM_LANE-1:0]             I_Lane_Commit,
  input  logic [NUM_LANE*WIDTH_ENTRY-1:0] I_Lane_Issue_No,
  output logic                            O_Commit,
  output logic [WIDTH_ENTRY-1:0]          O_Commit_No,
  output logic [WIDTH_ENTRY:0]            O_Pending,
  output logic                            O_Overflow,
  output logic                            O_Stray
);

  logic [NUM_ENTRY-1:0]   v;
  logic [WIDTH_ENTRY-1:0] issue_no  [NUM_ENTRY];
  logic [NUM_LANE-1:0]    en_lane   [NUM_ENTRY];
  logic [NUM_LANE-1:0]    en_commit [NUM_ENTRY];
  logic [WIDTH_ENTRY-1:0] head;
  logic [WIDTH_ENTRY-1:0] tail;
  logic [WIDTH_ENTRY:0]   count;

  logic [NUM_LANE-1:0]    set_mask_p0 [NUM_ENTRY];
  logic [NUM_LANE-1:0]    lane_hit_p0;
  logic                   stray_p0;
  logic                   retire_p0;
  logic                   issue_ok_p0;

  function automatic logic [WIDTH_ENTRY-1:0] ptr_inc(input logic [WIDTH_ENTRY-1:0] p);
    return (p == WIDTH_ENTRY'(NUM_ENTRY - 1)) ? '0 : p + WIDTH_ENTRY'(1);
  endfunction

  assign O_Pending = count;
  assign O_Full    = (count == (WIDTH_ENTRY + 1)'(NUM_ENTRY));
  assign O_Empty   = (count == '0);

  assign issue_ok_p0 = I_Issue && !O_Full;
  assign retire_p0   = v[head] && (en_commit[head] == en_lane[head]);

  // Stage p0: match every lane's commit report against the valid entries in parallel
  always_comb begin
    lane_hit_p0 = '0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      set_mask_p0[e] = '0;
      for (int l = 0; l < NUM_LANE; l++) begin
        if (I_Lane_Commit[l] && v[e] && en_lane[e][l] &&
            (issue_no[e] == I_Lane_Issue_No[l*WIDTH_ENTRY +: WIDTH_ENTRY])) begin
          set_mask_p0[e][l] = 1'b1;
          lane_hit_p0[l]    = 1'b1;
        end
      end
    end
    stray_p0 = |(I_Lane_Commit & ~lane_hit_p0);
  end

  // Stage p1: table update, in-order retire and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      v           <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      O_Commit    <= 1'b0;
      O_Commit_No <= '0;
      O_Overflow  <= 1'b0;
      O_Stray     <= 1'b0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        en_lane[e]   <= '0;
        en_commit[e] <= '0;
      end
    end else begin
      O_Commit <= retire_p0;
      O_Stray  <= stray_p0;
      if (I_Issue && O_Full) O_Overflow <= 1'b1;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        en_commit[e] <= en_commit[e] | set_mask_p0[e];
      end
      if (retire_p0) begin
        v[head]     <= 1'b0;
        O_Commit_No <= issue_no[head];
        head        <= ptr_inc(head);
      end
      // Full blocks issue, so the tail slot never collides with the slot retiring this edge
      if (issue_ok_p0) begin
        v[tail]         <= 1'b1;
        issue_no[tail]  <= I_Issue_No;
        en_lane[tail]   <= I_En_Lane;
        en_commit[tail] <= '0;
        tail            <= ptr_inc(tail);
      end
      count <= count + (WIDTH_ENTRY + 1)'(issue_ok_p0) - (WIDTH_ENTRY + 1)'(retire_p0);
    end
  end

endmodule

// File: tb/tb_vu_commit_table.sv
// Bench for vu_commit_table: directed scenarios plus randomized traffic, checked by a
// per-cycle scoreboard fed from a queue-based reference model of the commit table.
module tb_vu_commit_table;
  localparam int NL = 16;
  localparam int NE = 8;
  localparam int W  = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            I_Issue = 1'b0;
  logic [W-1:0]    I_Issue_No = '0;
  logic [NL-1:0]   I_En_Lane = '0;
  logic [NL-1:0]   I_Lane_Commit = '0;
  logic [NL*W-1:0] I_Lane_Issue_No = '0;
  logic            O_Full, O_Empty, O_Commit, O_Overflow, O_Stray;
  logic [W-1:0]    O_Commit_No;
  logic [W:0]      O_Pending;

  vu_commit_table #(.NUM_LANE(NL), .NUM_ENTRY(NE), .WIDTH_ENTRY(W)) dut (
    .clock(clock), .reset(reset), .I_Issue(I_Issue), .I_Issue_No(I_Issue_No),
    .I_En_Lane(I_En_Lane), .O_Full(O_Full), .O_Empty(O_Empty),
    .I_Lane_Commit(I_Lane_Commit), .I_Lane_Issue_No(I_Lane_Issue_No),
    .O_Commit(O_Commit), .O_Commit_No(O_Commit_No), .O_Pending(O_Pending),
    .O_Overflow(O_Overflow), .O_Stray(O_Stray)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int cyc; bit commit; int no; int pending; bit stray; bit ovf;} exp_t;
  typedef struct {int no; logic [NL-1:0] lanes; logic [NL-1:0] done;} ent_t;
  typedef struct {int cyc; int no;} log_t;
  exp_t sb[$];
  ent_t mq[$];
  log_t clog[$];
  bit   m_ovf = 1'b0;
  exp_t m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares every output
  always @(negedge clock) begin
    if (O_Commit === 1'b1) clog.push_back('{cyc, int'(O_Commit_No)});
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      m_e = sb.pop_front();
      check("commit", 32'(O_Commit), 32'(m_e.commit));
      if (m_e.commit) check("commit_no", 32'(O_Commit_No), 32'(m_e.no));
      check("pending", 32'(O_Pending), 32'(m_e.pending));
      check("full", 32'(O_Full), 32'(m_e.pending == NE));
      check("empty", 32'(O_Empty), 32'(m_e.pending == 0));
      check("stray", 32'(O_Stray), 32'(m_e.stray));
      check("overflow", 32'(O_Overflow), 32'(m_e.ovf));
    end
  end

  // Drives one cycle of inputs and advances the reference model across the coming edge
  task automatic tick(input bit rst, input bit iss, input int no, input logic [NL-1:0] lanes,
                      input logic [NL-1:0] lc, input logic [NL*W-1:0] lno);
    exp_t e;
    bit   full;
    bit   fin;
    reset = rst; I_Issue = iss; I_Issue_No = W'(no); I_En_Lane = lanes;
    I_Lane_Commit = lc; I_Lane_Issue_No = lno;
    e.cyc = cyc + 1; e.commit = 0; e.no = 0; e.stray = 0;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      full = (mq.size() == NE);
      fin  = (mq.size() > 0) && (mq[0].done == mq[0].lanes);
      for (int l = 0; l < NL; l++) begin
        if (lc[l]) begin
          bit hit;
          int q;
          hit = 1'b0;
          q = int'(lno[l*W +: W]);
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].no == q && mq[k].lanes[l]) begin
              mq[k].done[l] = 1'b1;
              hit = 1'b1;
            end
          end
          if (!hit) e.stray = 1'b1;
        end
      end
      if (fin) begin
        e.commit = 1'b1;
        e.no = mq[0].no;
        void'(mq.pop_front());
      end
      if (iss) begin
        if (full) m_ovf = 1'b1;
        else mq.push_back('{no, lanes, '0});
      end
    end
    e.pending = mq.size();
    e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 0, '0, '0, '0);
  endtask

  task automatic issue(input int no, input logic [NL-1:0] lanes);
    tick(1'b0, 1'b1, no, lanes, '0, '0);
  endtask

  task automatic commit(input int no, input logic [NL-1:0] mask);
    logic [NL*W-1:0] lno;
    for (int l = 0; l < NL; l++) lno[l*W +: W] = W'(no);
    tick(1'b0, 1'b0, 0, '0, mask, lno);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 0, '0, '0, '0);
    tick(1'b1, 1'b0, 0, '0, '0, '0);
  endtask

  initial begin
    int n;
    logic [NL*W-1:0] lno;
    @(posedge clock);
    #1;
    do_reset();
    idle(1);
    check("reset_empty", 32'(O_Empty), 32'd1);
    check("reset_pending", 32'(O_Pending), 32'd0);
    check("reset_commit_no", 32'(O_Commit_No), 32'd0);

    // Single command, four lanes
    clog.delete();
    issue(3, 16'h000F);
    idle(1);
    n = cyc;
    commit(3, 16'h000F);
    idle(4);
    check("t1_count", clog.size(), 1);
    if (clog.size() == 1) begin
      check("t1_no", clog[0].no, 3);
      check("t1_cyc", clog[0].cyc, n + 2);
    end

    // Younger command completes first but waits for the older one
    clog.delete();
    issue(1, 16'h0003);
    issue(2, 16'h0003);
    commit(2, 16'h0003);
    idle(2);
    n = cyc;
    commit(1, 16'h0003);
    idle(4);
    check("t2_count", clog.size(), 2);
    if (clog.size() == 2) begin
      check("t2_first", clog[0].no * 1000 + clog[0].cyc, 1 * 1000 + n + 2);
      check("t2_second", clog[1].no * 1000 + clog[1].cyc, 2 * 1000 + n + 3);
    end

    // Fill, overflow, retire one, refill across the pointer wrap, drain in order
    for (int i = 0; i < NE; i++) issue(i, NL'(1) << i);
    check("t3_full", 32'(O_Full), 32'd1);
    check("t3_pending", 32'(O_Pending), 32'd8);
    issue(0, 16'h0001);
    check("t3_overflow", 32'(O_Overflow), 32'd1);
    check("t3_pending_drop", 32'(O_Pending), 32'd8);
    commit(0, 16'h0001);
    idle(3);
    check("t3_pending_after_retire", 32'(O_Pending), 32'd7);
    issue(0, 16'h0100);
    check("t3_refill", 32'(O_Pending), 32'd8);
    clog.delete();
    for (int l = 0; l < NL; l++) lno[l*W +: W] = W'(l);
    lno[8*W +: W] = '0;
    tick(1'b0, 1'b0, 0, '0, 16'h01FE, lno);
    idle(12);
    check("t3_drain_count", clog.size(), 8);
    for (int k = 0; k < clog.size(); k++) begin
      check("t3_drain_no", clog[k].no, (k + 1) % NE);
      check("t3_drain_cyc", clog[k].cyc, clog[0].cyc + k);
    end
    check("t3_overflow_sticky", 32'(O_Overflow), 32'd1);
    do_reset();
    check("t3_overflow_cleared", 32'(O_Overflow), 32'd0);

    // Command with no enabled lanes
    clog.delete();
    n = cyc;
    issue(5, '0);
    idle(3);
    check("t4_count", clog.size(), 1);
    if (clog.size() == 1) check("t4_retire", clog[0].no * 1000 + clog[0].cyc, 5 * 1000 + n + 2);

    // Stray commit report
    lno = '0;
    lno[4*W +: W] = W'(6);
    tick(1'b0, 1'b0, 0, '0, 16'h0010, lno);
    check("t5_stray_pulse", 32'(O_Stray), 32'd1);
    idle(1);
    check("t5_stray_clear", 32'(O_Stray), 32'd0);
    check("t5_pending", 32'(O_Pending), 32'd0);

    // Partially committed command dropped by reset
    clog.delete();
    issue(7, 16'hFFFF);
    idle(1);
    commit(7, 16'h7FFF);
    tick(1'b1, 1'b0, 0, '0, '0, '0);
    idle(5);
    check("t6_no_commit", clog.size(), 0);
    check("t6_empty", 32'(O_Empty), 32'd1);
    check("t6_pending", 32'(O_Pending), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      bit              rst, iss;
      int              no, r, k, nfree;
      int              free_no[NE];
      logic [NL-1:0]   lanes, lc;
      rst = ($urandom % 400 == 0);
      iss = ($urandom % 5 < 2);
      nfree = 0;
      for (int c = 0; c < NE; c++) begin
        bit used;
        used = 1'b0;
        foreach (mq[j]) if (mq[j].no == c) used = 1'b1;
        if (!used) begin free_no[nfree] = c; nfree++; end
      end
      no = (nfree > 0) ? free_no[$urandom % nfree] : int'($urandom % NE);
      r = $urandom % 8;
      lanes = (r == 0) ? '0 : (r == 1) ? '1 : NL'($urandom) & NL'($urandom);
      lc = '0;
      lno = '0;
      for (int l = 0; l < NL; l++) begin
        r = $urandom % 6;
        if (r < 2 && mq.size() > 0) begin
          k = $urandom % mq.size();
          if (mq[k].lanes[l] || ($urandom % 20 == 0)) begin
            lc[l] = 1'b1;
            lno[l*W +: W] = W'(mq[k].no);
          end
        end else if (r == 2 && ($urandom % 30 == 0)) begin
          lc[l] = 1'b1;
          lno[l*W +: W] = W'($urandom);
        end
      end
      tick(rst, iss, no, lanes, lc, lno);
    end
    idle(20);
    @(negedge clock);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
